// File: rtl/gf180mcu_ef_io__bi_ctrl_if.sv
// Core-side bundle of the bidirectional pad controller: direction handshake,
// configuration write channel, output data and the conditioned input data.
// master = core logic, slave = pad controller.
interface gf180mcu_ef_io__bi_ctrl_if;
    logic       dir_req;    // requested direction: 1=output, 0=input
    logic       dir_ack;    // pad is in the stable output state
    logic       cfg_valid;  // configuration write request
    logic       cfg_ready;  // write can be accepted this cycle
    logic [5:0] cfg_data;   // {pdrv1, pdrv0, sl, cs, pd, pu}
    logic       dout;       // data to drive onto the pad
    logic       din;        // synchronized, debounced pad input
    logic       din_rise;   // one-cycle pulse on din 0->1
    logic       din_fall;   // one-cycle pulse on din 1->0

    modport master (
        output dir_req, cfg_valid, cfg_data, dout,
        input  dir_ack, cfg_ready, din, din_rise, din_fall
    );

    modport slave (
        input  dir_req, cfg_valid, cfg_data, dout,
        output dir_ack, cfg_ready, din, din_rise, din_fall
    );
endinterface

// File: rtl/gf180mcu_ef_io__bi_ctrl.sv
// Purpose: direction sequencing, configuration and input conditioning for a bidirectional pad.
// Latency: direction change takes TA_CYCLES idle cycles; cfg applies next cycle; y->din is 2+max(DB_CYCLES,1) edges.
// Backpressure: cfg_ready low during turnaround; dir_req ignored until the turnaround has landed.
// Ports: clk, rn (async active-low); core (interface slave modport);
//        cs/sl/pu/pd/pdrv0/pdrv1/ie/oe/a pad-cell controls (all flops); y asynchronous pad input.
module gf180mcu_ef_io__bi_ctrl #(
    parameter int TA_CYCLES = 2,   // 1..15
    parameter int DB_CYCLES = 0    // 0..255, 0 behaves as 1
) (
    input  logic clk,
    input  logic rn,
    gf180mcu_ef_io__bi_ctrl_if.slave core,
    output logic cs,
    output logic sl,
    output logic pu,
    output logic pd,
    output logic pdrv0,
    output logic pdrv1,
    output logic ie,
    output logic oe,
    output logic a,
    input  logic y
);

    localparam int         DB_MAX  = (DB_CYCLES == 0) ? 1 : DB_CYCLES;
    localparam logic [3:0] TA_LAST = 4'(TA_CYCLES - 1);
    localparam logic [7:0] DB_LAST = 8'(DB_MAX - 1);

    typedef enum logic [1:0] {
        ST_IN     = 2'd0,
        ST_TA_OUT = 2'd1,
        ST_OUT    = 2'd2,
        ST_TA_IN  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] ta_cnt, ta_cnt_nxt;

    logic [5:0] cfg_q, cfg_nxt;
    logic       accept;
    logic       pull_en;

    logic       dir_ack_q, cfg_ready_q;
    logic       s1, s2;
    logic [7:0] db_cnt;
    logic       din_q, din_rise_q, din_fall_q;

    // Direction sequencing. Requests are only looked at in the two stable
    // states, so a request that flips mid-turnaround is seen after landing.
    always_comb begin
        state_nxt  = state;
        ta_cnt_nxt = ta_cnt;
        case (state)
            ST_IN: begin
                if (core.dir_req) begin
                    state_nxt  = ST_TA_OUT;
                    ta_cnt_nxt = 4'd0;
                end
            end
            ST_TA_OUT: begin
                if (ta_cnt == TA_LAST) begin
                    state_nxt  = ST_OUT;
                    ta_cnt_nxt = 4'd0;
                end else begin
                    ta_cnt_nxt = ta_cnt + 4'd1;
                end
            end
            ST_OUT: begin
                if (!core.dir_req) begin
                    state_nxt  = ST_TA_IN;
                    ta_cnt_nxt = 4'd0;
                end
            end
            ST_TA_IN: begin
                if (ta_cnt == TA_LAST) begin
                    state_nxt  = ST_IN;
                    ta_cnt_nxt = 4'd0;
                end else begin
                    ta_cnt_nxt = ta_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt  = ST_IN;
                ta_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Pad controls are registered from the next state/config so that every
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        accept  = core.cfg_valid && cfg_ready_q;
        cfg_nxt = accept ? core.cfg_data : cfg_q;
        // pu and pd both set is treated as "no pull" rather than a fight.
        pull_en = (state_nxt == ST_IN) && !(cfg_nxt[0] && cfg_nxt[1]);
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state       <= ST_IN;
            ta_cnt      <= 4'd0;
            cfg_q       <= 6'd0;
            ie          <= 1'b1;
            oe          <= 1'b0;
            dir_ack_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            pu          <= 1'b0;
            pd          <= 1'b0;
            cs          <= 1'b0;
            sl          <= 1'b0;
            pdrv0       <= 1'b0;
            pdrv1       <= 1'b0;
            a           <= 1'b0;
        end else begin
            state       <= state_nxt;
            ta_cnt      <= ta_cnt_nxt;
            cfg_q       <= cfg_nxt;
            ie          <= (state_nxt == ST_IN);
            oe          <= (state_nxt == ST_OUT);
            dir_ack_q   <= (state_nxt == ST_OUT);
            cfg_ready_q <= (state_nxt == ST_IN) || (state_nxt == ST_OUT);
            pu          <= pull_en && cfg_nxt[0];
            pd          <= pull_en && cfg_nxt[1];
            cs          <= cfg_nxt[2];
            sl          <= cfg_nxt[3];
            pdrv0       <= cfg_nxt[4];
            pdrv1       <= cfg_nxt[5];
            a           <= core.dout;
        end
    end

    // Input path: 2-flop synchronizer then a run-length debounce. The whole
    // path freezes outside IN because the input buffer is disabled there.
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            db_cnt     <= 8'd0;
            din_q      <= 1'b0;
            din_rise_q <= 1'b0;
            din_fall_q <= 1'b0;
        end else begin
            din_rise_q <= 1'b0;
            din_fall_q <= 1'b0;
            if (state == ST_IN) begin
                s1 <= y;
                s2 <= s1;
                if (s2 != din_q) begin
                    if (db_cnt == DB_LAST) begin
                        din_q      <= s2;
                        din_rise_q <= s2;
                        din_fall_q <= !s2;
                        db_cnt     <= 8'd0;
                    end else if (db_cnt != 8'hFF) begin
                        db_cnt <= db_cnt + 8'd1;
                    end
                end else begin
                    db_cnt <= 8'd0;
                end
            end
        end
    end

    assign core.dir_ack   = dir_ack_q;
    assign core.cfg_ready = cfg_ready_q;
    assign core.din       = din_q;
    assign core.din_rise  = din_rise_q;
    assign core.din_fall  = din_fall_q;

endmodule

// File: doc/gf180mcu_ef_io__bi_ctrl.md
GF180MCU_EF_IO__BI_CTRL -- requirements
Module: gf180mcu_ef_io__bi_ctrl

Interface
REQ-001 Parameter TA_CYCLES, default 2: turnaround cycles with IE=0 and OE=0; legal range 1..15.
REQ-002 Parameter DB_CYCLES, default 0: input debounce length in cycles; 0 is treated as 1; legal range 0..255.
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RN  in  1  reset, asynchronous, active-low.
REQ-005 DIR_REQ  in  1  requested pad direction: 1=output, 0=input.
REQ-006 DIR_ACK  out  1  1 while the pad is in the stable output state.
REQ-007 CFG_VALID  in  1  configuration write request.
REQ-008 CFG_READY  out  1  configuration write can be accepted.
REQ-009 CFG_DATA  in  6  {PDRV1,PDRV0,SL,CS,PD,PU}.
REQ-010 DOUT  in  1  core data to drive onto the pad.
REQ-011 DIN  out  1  synchronized, debounced pad input.
REQ-012 DIN_RISE / DIN_FALL  out  1 each  single-cycle pulses on DIN 0->1 / 1->0.
REQ-013 CS, SL, PU, PD, PDRV0, PDRV1, IE, OE, A  out  1 each  pad-cell controls, all driven from flops.
REQ-014 Y  in  1  pad-cell input data, asynchronous to CLK.

Function
REQ-015 Direction FSM states: IN (IE=1, OE=0), TA_OUT (IE=0, OE=0), OUT (IE=0, OE=1), TA_IN (IE=0, OE=0).
REQ-016 IN with DIR_REQ=1 at edge k: enter TA_OUT at edge k; enter OUT at edge k+TA_CYCLES; DIR_ACK rises with OE.
REQ-017 OUT with DIR_REQ=0 at edge k: enter TA_IN at edge k; DIR_ACK falls and OE falls at edge k; IE rises at edge k+TA_CYCLES.
REQ-018 DIR_REQ changes during TA_OUT/TA_IN are ignored; the turnaround completes and DIR_REQ is re-evaluated in the landing state on the next edge.
REQ-019 IE and OE are never 1 in the same cycle, including across reset assertion and deassertion.
REQ-020 CFG_READY=1 only in IN or OUT; a write is accepted on an edge with CFG_VALID=1 and CFG_READY=1.
REQ-021 Configuration outputs take the accepted value on the edge after acceptance.
REQ-022 Back-to-back writes are accepted every cycle; the last accepted value wins.
REQ-023 PU/PD outputs: forced 0 in OUT, TA_OUT and TA_IN.
REQ-024 PU/PD outputs in IN: the stored bits, except stored PU=PD=1 drives both 0 (no pull).
REQ-025 A is registered from DOUT every cycle, independent of state.
REQ-026 Y passes through a 2-flop synchronizer (s1, s2).
REQ-027 Debounce counter increments each edge while s2!=DIN and clears on any edge with s2==DIN.
REQ-028 DIN toggles on the edge at which the count would reach max(DB_CYCLES,1), then the counter clears.
REQ-029 An isolated Y change is therefore visible on DIN at edge 2+max(DB_CYCLES,1) after Y is first sampled.
REQ-030 Outside IN, the synchronizer, counter and DIN hold their values; no edge pulses are produced.
REQ-031 DIN_RISE/DIN_FALL assert for exactly one cycle, on the edge DIN changes.
REQ-032 The counter saturates and never wraps.

Reset
REQ-033 RN low asynchronously forces: state IN, IE=1, OE=0, DIR_ACK=0, CFG_READY=1.
REQ-034 RN low also forces CS=SL=PU=PD=PDRV0=PDRV1=0 and A=0.
REQ-035 RN low also forces DIN=0, DIN_RISE=DIN_FALL=0, s1=s2=0 and counter=0.
REQ-036 Reset in any state, including mid-turnaround, drives OE=0 immediately without waiting for CLK.
REQ-037 The first transition after reset release occurs no earlier than the first rising edge with RN high.

Verification
REQ-038 TA_CYCLES=2; DIR_REQ 0->1 sampled at edge 10 -> IE=0 at edge 10, OE=1 and DIR_ACK=1 at edge 12, IE=OE=0 at edge 11.
REQ-039 In OUT, DIR_REQ=0 at edge 20, then DIR_REQ=1 at edge 21 -> IE=1 at edge 22, TA_OUT at edge 23, OE=1 at edge 25.
REQ-040 DB_CYCLES=3; Y 0->1 before edge 1 -> DIN=1 and DIN_RISE=1 at edge 5, DIN_RISE=0 at edge 6.
REQ-041 DB_CYCLES=3; a 2-cycle Y glitch -> DIN stays 0 and no pulse is produced.
REQ-042 CFG_DATA=6'b000011 written in IN -> PU=PD=0 next cycle; CFG_DATA=6'b000001 -> PU=1, then PU=0 after entering TA_OUT.
REQ-043 RN asserted mid-TA_OUT with CFG_VALID=1 held -> IN with IE=1 and all reset values immediately; the write is not applied; CFG_READY=1.
